dcache_req_ctrl: RTL and testbench
==================================

DCACHE_REQ_CTRL -- requirements
Module: dcache_req_ctrl

Interface
REQ-001 SHALL have ports: clock  in  1  system clock; reset  in  1  synchronous, active-high reset, clock clock.
REQ-002 SHALL have ports: lsq_req_valid  in  1  LSQ request; lsq_req_is_store  in  1  store=1/load=0; lsq_req_addr  in  64  byte address; lsq_req_data  in  64  store data; lsq_req_rob_idx  in  ROB_IDX_W  owner tag; lsq_req_ready  out  1  request accepted this cycle.
REQ-003 SHALL have ports: lsq_resp_valid  out  1  load data return; lsq_resp_data  out  64  load data; lsq_resp_rob_idx  out  ROB_IDX_W  owner tag.
REQ-004 SHALL have ports to the cache array: index_out  out  DCACHE_INDEX_SIZE; tag_out  out  DCACHE_TAG_SIZE; read_enable  out  1; write_enable  out  1; write_data_out  out  64; data_is_valid, data_is_miss, data_is_dirty, cache_is_full  in  1 each; cache_data_in  in  64; victim_tag_in  in  DCACHE_TAG_SIZE  tag of the LRU way at index_out.
REQ-005 SHALL have ports to memory: mem_command  out  2  BUS_NONE/BUS_LOAD/BUS_STORE; mem_addr  out  64; mem_response  in  4  transaction tag, 0 = rejected; mem_tag  in  4  completing tag, 0 = none.
REQ-006 SHALL use parameter MSHR_DEPTH, default 4, number of outstanding line fills.

Function
REQ-007 SHALL decompose the address as offset = addr[2:0], index = addr[3 +: DCACHE_INDEX_SIZE], tag = remaining upper DCACHE_TAG_SIZE bits.
REQ-008 SHALL implement FSM states IDLE, LOOKUP, WRITEBACK, FILL_REQ.
REQ-009 SHALL assert lsq_req_ready only in IDLE with at least one free MSHR entry; valid&ready latches addr/data/is_store/rob_idx and moves to LOOKUP.
REQ-010 SHALL, in LOOKUP, drive index_out/tag_out from the latched address and assert read_enable (load) or write_enable (store) with write_data_out = latched data; outputs are combinational from state registers.
REQ-011 SHALL, on load hit (data_is_valid) in LOOKUP, register cache_data_in and rob_idx into lsq_resp_* (valid exactly one cycle later) and return to IDLE.
REQ-012 SHALL, on store hit or clean store miss (data_is_valid=1 after write), return to IDLE with no LSQ response.
REQ-013 SHALL, on miss with cache_is_full=1, remain in LOOKUP and re-present the same access next cycle.
REQ-014 SHALL, on miss with data_is_dirty=1, enter WRITEBACK: mem_command = BUS_STORE, mem_addr = {victim_tag_in, index, 3'b000}; stay until mem_response != 0, then enter FILL_REQ.
REQ-015 SHALL, on clean load miss, enter FILL_REQ directly.
REQ-016 SHALL, in FILL_REQ, drive mem_command = BUS_LOAD, mem_addr = {tag, index, 3'b000}, and read_enable with the same index/tag so the array records mem_response; on mem_response != 0, allocate the lowest free MSHR entry {valid, mem_response, rob_idx, is_load} and return to IDLE; on mem_response == 0, retry next cycle.
REQ-017 SHALL, when mem_tag != 0 matches a valid MSHR entry, free that entry and, if is_load, register cache_data_in and the entry's rob_idx into lsq_resp_* for one cycle.
REQ-018 SHALL ignore mem_tag values that match no valid entry.
REQ-019 SHALL give fill completion priority over a same-cycle LOOKUP load hit; the hit is not consumed and LOOKUP repeats next cycle.
REQ-020 SHALL keep mem_command = BUS_NONE and mem_addr = 0 outside WRITEBACK/FILL_REQ.
REQ-021 SHALL tolerate mem_tag completion and MSHR allocation in the same cycle, including reuse of the freed entry.

Reset
REQ-022 SHALL, on reset, force state = IDLE, clear all MSHR valid bits, and drive lsq_req_ready=0, lsq_resp_valid=0, lsq_resp_data=0, lsq_resp_rob_idx=0, read_enable=0, write_enable=0, mem_command=BUS_NONE, mem_addr=0, index_out=0, tag_out=0, write_data_out=0 during the reset cycle.
REQ-023 SHALL abandon in-flight requests on reset mid-operation; late mem_tag returns are dropped per REQ-018.

Structure
REQ-024 SHALL take BUS_* encodings, DCACHE_INDEX_SIZE, DCACHE_TAG_SIZE and ROB_IDX_W from the shared sys_defs package, and define the FSM state enum and MSHR entry struct there.
REQ-025 SHALL place the MSHR table (allocate, match, free, full flag) in one sub-module, dcache_mshr.

Verification
REQ-026 SHALL cover load hit: preload line, load addr 0x40 rob 5 -> lsq_resp_valid at cycle 2 after accept, data matches, rob_idx=5.
REQ-027 SHALL cover clean load miss: mem_response=3 -> BUS_LOAD addr 0x80; mem_tag=3 three cycles later -> one-cycle resp with load data and original rob_idx.
REQ-028 SHALL cover dirty miss: victim dirty, victim_tag=0x12 -> BUS_STORE to victim address first, then BUS_LOAD; mem_response=0 twice -> command held two extra cycles.
REQ-029 SHALL cover MSHR full: 4 outstanding misses -> lsq_req_ready=0 until any mem_tag completes, then 1 next cycle.
REQ-030 SHALL cover collision and reset: fill completion concurrent with load hit -> fill returned first, hit one cycle later; reset with 2 outstanding fills -> their later mem_tags produce no lsq_resp_valid.

Source files
------------

// File: rtl/sys_defs.sv
// Shared data-cache definitions: geometry, bus command encodings, request FSM
// states and the MSHR entry layout used by the request controller.
package sys_defs;

  localparam int DCACHE_INDEX_SIZE = 5;
  localparam int DCACHE_TAG_SIZE   = 64 - 3 - DCACHE_INDEX_SIZE;
  localparam int DCACHE_LINE_W     = DCACHE_TAG_SIZE + DCACHE_INDEX_SIZE;
  localparam int ROB_IDX_W         = 5;
  localparam int MEM_TAG_W         = 4;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    FILL_REQ
  } dcache_state_e;

  typedef struct packed {
    logic                 valid;
    logic [MEM_TAG_W-1:0] mem_tag;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic                 is_load;
  } mshr_entry_t;

  // Byte address of the first byte of a cache line.
  function automatic logic [63:0] line_addr(input logic [DCACHE_TAG_SIZE-1:0]   tag,
                                            input logic [DCACHE_INDEX_SIZE-1:0] index);
    return {tag, index, 3'b000};
  endfunction

endpackage

// File: rtl/dcache_mshr.sv
// Miss status holding registers: tracks outstanding line fills by memory tag,
// allocates the lowest free slot and frees a slot when its tag completes.
module dcache_mshr
  import sys_defs::*;
#(
  parameter int MSHR_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 alloc_en,
  input  logic [MEM_TAG_W-1:0] alloc_tag,
  input  logic [ROB_IDX_W-1:0] alloc_rob_idx,
  input  logic                 alloc_is_load,
  input  logic [MEM_TAG_W-1:0] cmpl_tag,
  output logic                 cmpl_hit,
  output logic                 cmpl_is_load,
  output logic [ROB_IDX_W-1:0] cmpl_rob_idx,
  output logic                 full
);

  mshr_entry_t [MSHR_DEPTH-1:0] entries_q, entries_d;
  logic                         alloc_done;

  always_comb begin
    entries_d    = entries_q;
    cmpl_hit     = 1'b0;
    cmpl_is_load = 1'b0;
    cmpl_rob_idx = '0;
    alloc_done   = 1'b0;
    full         = 1'b1;

    for (int i = 0; i < MSHR_DEPTH; i++) begin
      full = full & entries_q[i].valid;
      if (!cmpl_hit && (cmpl_tag != '0) && entries_q[i].valid &&
          (entries_q[i].mem_tag == cmpl_tag)) begin
        cmpl_hit           = 1'b1;
        cmpl_is_load       = entries_q[i].is_load;
        cmpl_rob_idx       = entries_q[i].rob_idx;
        entries_d[i].valid = 1'b0;
      end
    end

    // Allocation looks at the post-completion view so a slot freed this
    // cycle can be handed out again immediately.
    for (int i = 0; i < MSHR_DEPTH; i++) begin
      if (alloc_en && !alloc_done && !entries_d[i].valid) begin
        entries_d[i] = '{valid: 1'b1, mem_tag: alloc_tag,
                         rob_idx: alloc_rob_idx, is_load: alloc_is_load};
        alloc_done   = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      entries_q <= '0;
    end else begin
      entries_q <= entries_d;
    end
  end

endmodule

// File: rtl/dcache_req_ctrl.sv
// Data-cache request controller: accepts one LSQ access at a time, probes the
// array, writes back dirty victims, issues line fills and returns load data.
module dcache_req_ctrl
  import sys_defs::*;
#(
  parameter int MSHR_DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,

  input  logic                         lsq_req_valid,
  input  logic                         lsq_req_is_store,
  input  logic [63:0]                  lsq_req_addr,
  input  logic [63:0]                  lsq_req_data,
  input  logic [ROB_IDX_W-1:0]         lsq_req_rob_idx,
  output logic                         lsq_req_ready,

  output logic                         lsq_resp_valid,
  output logic [63:0]                  lsq_resp_data,
  output logic [ROB_IDX_W-1:0]         lsq_resp_rob_idx,

  output logic [DCACHE_INDEX_SIZE-1:0] index_out,
  output logic [DCACHE_TAG_SIZE-1:0]   tag_out,
  output logic                         read_enable,
  output logic                         write_enable,
  output logic [63:0]                  write_data_out,
  input  logic                         data_is_valid,
  input  logic                         data_is_miss,
  input  logic                         data_is_dirty,
  input  logic                         cache_is_full,
  input  logic [63:0]                  cache_data_in,
  input  logic [DCACHE_TAG_SIZE-1:0]   victim_tag_in,

  output logic [1:0]                   mem_command,
  output logic [63:0]                  mem_addr,
  input  logic [MEM_TAG_W-1:0]         mem_response,
  input  logic [MEM_TAG_W-1:0]         mem_tag
);

  dcache_state_e               state_q, state_d;
  logic [DCACHE_LINE_W-1:0]    line_q, line_d;
  logic [63:0]                 data_q, data_d;
  logic                        is_store_q, is_store_d;
  logic [ROB_IDX_W-1:0]        rob_idx_q, rob_idx_d;
  logic                        resp_valid_q, resp_valid_d;
  logic [63:0]                 resp_data_q, resp_data_d;
  logic [ROB_IDX_W-1:0]        resp_rob_idx_q, resp_rob_idx_d;

  logic                        mshr_full;
  logic                        alloc_en;
  logic                        cmpl_hit;
  logic                        cmpl_is_load;
  logic [ROB_IDX_W-1:0]        cmpl_rob_idx;

  logic [DCACHE_INDEX_SIZE-1:0] line_index;
  logic [DCACHE_TAG_SIZE-1:0]   line_tag;
  logic                         unused_offset;

  assign line_index    = line_q[DCACHE_INDEX_SIZE-1:0];
  assign line_tag      = line_q[DCACHE_INDEX_SIZE +: DCACHE_TAG_SIZE];
  assign unused_offset = ^lsq_req_addr[2:0];

  dcache_mshr #(.MSHR_DEPTH(MSHR_DEPTH)) u_mshr (
    .clock         (clock),
    .reset         (reset),
    .alloc_en      (alloc_en),
    .alloc_tag     (mem_response),
    .alloc_rob_idx (rob_idx_q),
    .alloc_is_load (!is_store_q),
    .cmpl_tag      (mem_tag),
    .cmpl_hit      (cmpl_hit),
    .cmpl_is_load  (cmpl_is_load),
    .cmpl_rob_idx  (cmpl_rob_idx),
    .full          (mshr_full)
  );

  always_comb begin
    state_d        = state_q;
    line_d         = line_q;
    data_d         = data_q;
    is_store_d     = is_store_q;
    rob_idx_d      = rob_idx_q;
    resp_valid_d   = 1'b0;
    resp_data_d    = resp_data_q;
    resp_rob_idx_d = resp_rob_idx_q;
    alloc_en       = 1'b0;

    if (cmpl_hit && cmpl_is_load) begin
      resp_valid_d   = 1'b1;
      resp_data_d    = cache_data_in;
      resp_rob_idx_d = cmpl_rob_idx;
    end

    case (state_q)
      IDLE: begin
        if (lsq_req_valid && lsq_req_ready) begin
          line_d     = lsq_req_addr[63:3];
          data_d     = lsq_req_data;
          is_store_d = lsq_req_is_store;
          rob_idx_d  = lsq_req_rob_idx;
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        if (data_is_valid) begin
          if (is_store_q) begin
            state_d = IDLE;
          end else if (!cmpl_hit) begin
            // A completing fill owns the response port; the hit is replayed.
            resp_valid_d   = 1'b1;
            resp_data_d    = cache_data_in;
            resp_rob_idx_d = rob_idx_q;
            state_d        = IDLE;
          end
        end else if (data_is_miss && !cache_is_full) begin
          state_d = data_is_dirty ? WRITEBACK : FILL_REQ;
        end
      end
      WRITEBACK: begin
        if (mem_response != '0) state_d = FILL_REQ;
      end
      FILL_REQ: begin
        if (mem_response != '0) begin
          alloc_en = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      line_q         <= '0;
      data_q         <= '0;
      is_store_q     <= 1'b0;
      rob_idx_q      <= '0;
      resp_valid_q   <= 1'b0;
      resp_data_q    <= '0;
      resp_rob_idx_q <= '0;
    end else begin
      state_q        <= state_d;
      line_q         <= line_d;
      data_q         <= data_d;
      is_store_q     <= is_store_d;
      rob_idx_q      <= rob_idx_d;
      resp_valid_q   <= resp_valid_d;
      resp_data_q    <= resp_data_d;
      resp_rob_idx_q <= resp_rob_idx_d;
    end
  end

  // Array and bus outputs decode straight from the state registers and are
  // held at zero throughout the reset cycle.
  always_comb begin
    lsq_req_ready    = 1'b0;
    lsq_resp_valid   = 1'b0;
    lsq_resp_data    = '0;
    lsq_resp_rob_idx = '0;
    index_out        = '0;
    tag_out          = '0;
    read_enable      = 1'b0;
    write_enable     = 1'b0;
    write_data_out   = '0;
    mem_command      = BUS_NONE;
    mem_addr         = '0;

    if (!reset) begin
      lsq_req_ready    = (state_q == IDLE) && !mshr_full;
      lsq_resp_valid   = resp_valid_q;
      lsq_resp_data    = resp_data_q;
      lsq_resp_rob_idx = resp_rob_idx_q;
      if (state_q != IDLE) begin
        index_out = line_index;
        tag_out   = line_tag;
      end
      case (state_q)
        LOOKUP: begin
          read_enable  = !is_store_q;
          write_enable = is_store_q;
          if (is_store_q) write_data_out = data_q;
        end
        WRITEBACK: begin
          mem_command = BUS_STORE;
          mem_addr    = line_addr(victim_tag_in, line_index);
        end
        FILL_REQ: begin
          mem_command = BUS_LOAD;
          mem_addr    = line_addr(line_tag, line_index);
          read_enable = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_req_ctrl.sv
// Self-checking bench for dcache_req_ctrl: transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dcache_req_ctrl;
  import sys_defs::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        lsq_req_valid = 1'b0, lsq_req_is_store = 1'b0;
  logic [63:0] lsq_req_addr = '0, lsq_req_data = '0;
  logic [4:0]  lsq_req_rob_idx = '0;
  logic        lsq_req_ready;
  logic        lsq_resp_valid;
  logic [63:0] lsq_resp_data;
  logic [4:0]  lsq_resp_rob_idx;
  logic [4:0]  index_out;
  logic [55:0] tag_out;
  logic        read_enable, write_enable;
  logic [63:0] write_data_out;
  logic        data_is_valid = 1'b0, data_is_miss = 1'b0, data_is_dirty = 1'b0, cache_is_full = 1'b0;
  logic [63:0] cache_data_in = '0;
  logic [55:0] victim_tag_in = '0;
  logic [1:0]  mem_command;
  logic [63:0] mem_addr;
  logic [3:0]  mem_response = '0, mem_tag = '0;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  dcache_req_ctrl #(.MSHR_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .lsq_req_valid(lsq_req_valid), .lsq_req_is_store(lsq_req_is_store),
    .lsq_req_addr(lsq_req_addr), .lsq_req_data(lsq_req_data),
    .lsq_req_rob_idx(lsq_req_rob_idx), .lsq_req_ready(lsq_req_ready),
    .lsq_resp_valid(lsq_resp_valid), .lsq_resp_data(lsq_resp_data),
    .lsq_resp_rob_idx(lsq_resp_rob_idx),
    .index_out(index_out), .tag_out(tag_out), .read_enable(read_enable),
    .write_enable(write_enable), .write_data_out(write_data_out),
    .data_is_valid(data_is_valid), .data_is_miss(data_is_miss),
    .data_is_dirty(data_is_dirty), .cache_is_full(cache_is_full),
    .cache_data_in(cache_data_in), .victim_tag_in(victim_tag_in),
    .mem_command(mem_command), .mem_addr(mem_addr),
    .mem_response(mem_response), .mem_tag(mem_tag)
  );

  // Reference model: one pending access plus a table of outstanding fills.
  // m_step: 0 none, 1 probing the array, 2 writing back victim, 3 requesting fill
  int          m_step = 0;
  logic [63:0] m_addr = '0, m_data = '0;
  bit          m_store = 1'b0;
  int          m_rob = 0;
  bit          fv[4];
  int          ft[4];
  int          fr[4];
  bit          fl[4];
  bit          m_rv = 1'b0;
  logic [63:0] m_rd = '0;
  int          m_rr = 0;
  bit          m_ready = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  function automatic int fills_used();
    int n = 0;
    for (int j = 0; j < 4; j++) if (fv[j]) n++;
    return n;
  endfunction

  function automatic bit tag_busy(input int t);
    for (int j = 0; j < 4; j++) if (fv[j] && ft[j] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic settle();
    logic [63:0] e_idx, e_tag, e_wd, e_maddr;
    bit          e_ready, e_re, e_we;
    logic [63:0] e_cmd;
    #2;
    e_ready = 0; e_re = 0; e_we = 0; e_idx = 0; e_tag = 0; e_wd = 0; e_maddr = 0; e_cmd = 0;
    if (!reset) begin
      e_ready = (m_step == 0) && (fills_used() < 4);
      if (m_step != 0) begin
        e_idx = (m_addr >> 3) & 64'd31;
        e_tag = m_addr >> 8;
      end
      e_re = (m_step == 1 && !m_store) || m_step == 3;
      e_we = (m_step == 1 && m_store);
      if (e_we) e_wd = m_data;
      if (m_step == 2) begin
        e_cmd   = 64'd2;
        e_maddr = ({8'h00, victim_tag_in} << 8) | (m_addr & 64'hF8);
      end else if (m_step == 3) begin
        e_cmd   = 64'd1;
        e_maddr = m_addr & ~64'h7;
      end
    end
    m_ready = e_ready;
    chk("ready", 64'(lsq_req_ready), 64'(e_ready));
    chk("index", 64'(index_out), e_idx);
    chk("tag", 64'(tag_out), e_tag);
    chk("rd_en", 64'(read_enable), 64'(e_re));
    chk("wr_en", 64'(write_enable), 64'(e_we));
    chk("wr_data", write_data_out, e_wd);
    chk("mem_cmd", 64'(mem_command), e_cmd);
    chk("mem_addr", mem_addr, e_maddr);
    chk("resp_valid", 64'(lsq_resp_valid), 64'(m_rv && !reset));
    if (reset) begin
      chk("resp_data_rst", lsq_resp_data, 64'd0);
      chk("resp_rob_rst", 64'(lsq_resp_rob_idx), 64'd0);
    end else if (m_rv) begin
      chk("resp_data", lsq_resp_data, m_rd);
      chk("resp_rob", 64'(lsq_resp_rob_idx), 64'(m_rr));
    end
  endtask

  task automatic advance();
    int found;
    bit nrv;
    logic [63:0] nrd;
    int nrr;
    if (reset) begin
      m_step = 0;
      for (int j = 0; j < 4; j++) fv[j] = 1'b0;
      m_rv = 1'b0; m_rd = '0; m_rr = 0;
    end else begin
      found = -1;
      nrv = 1'b0; nrd = m_rd; nrr = m_rr;
      if (mem_tag != 4'd0)
        for (int j = 0; j < 4; j++)
          if (found < 0 && fv[j] && ft[j] == int'(mem_tag)) found = j;
      if (found >= 0) begin
        fv[found] = 1'b0;
        if (fl[found]) begin nrv = 1'b1; nrd = cache_data_in; nrr = fr[found]; end
      end
      case (m_step)
        0: if (lsq_req_valid && m_ready) begin
             m_addr = lsq_req_addr; m_data = lsq_req_data;
             m_store = lsq_req_is_store; m_rob = int'(lsq_req_rob_idx);
             m_step = 1;
           end
        1: if (data_is_valid) begin
             if (m_store) m_step = 0;
             else if (found < 0) begin
               nrv = 1'b1; nrd = cache_data_in; nrr = m_rob; m_step = 0;
             end
           end else if (data_is_miss && !cache_is_full) begin
             m_step = data_is_dirty ? 2 : 3;
           end
        2: if (mem_response != 4'd0) m_step = 3;
        3: if (mem_response != 4'd0) begin
             for (int j = 0; j < 4; j++)
               if (m_step == 3 && !fv[j]) begin
                 fv[j] = 1'b1; ft[j] = int'(mem_response); fr[j] = m_rob; fl[j] = !m_store;
                 m_step = 0;
               end
           end
        default: m_step = 0;
      endcase
      m_rv = nrv; m_rd = nrd; m_rr = nrr;
    end
    @(negedge clock);
  endtask

  task automatic clr();
    reset = 1'b0;
    lsq_req_valid = 1'b0; lsq_req_is_store = 1'b0;
    lsq_req_addr = '0; lsq_req_data = '0; lsq_req_rob_idx = '0;
    data_is_valid = 1'b0; data_is_miss = 1'b0; data_is_dirty = 1'b0; cache_is_full = 1'b0;
    cache_data_in = '0; victim_tag_in = '0;
    mem_response = '0; mem_tag = '0;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic miss_alloc(input logic [63:0] addr, input logic [4:0] rob, input logic [3:0] rsp);
    clr(); lsq_req_valid = 1'b1; lsq_req_addr = addr; lsq_req_rob_idx = rob; step();
    clr(); data_is_miss = 1'b1; step();
    clr(); mem_response = rsp; step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r64;
    int r, j;
    @(negedge clock);
    reset = 1'b1;
    settle();
    chk("rst_ready", 64'(lsq_req_ready), 64'd0);
    chk("rst_cmd", 64'(mem_command), 64'd0);
    advance();

    // Load hit: addr 0x40, rob 5
    clr(); lsq_req_valid = 1'b1; lsq_req_addr = 64'h40; lsq_req_rob_idx = 5'd5;
    settle(); chk("a_ready", 64'(lsq_req_ready), 64'd1); advance();
    clr(); data_is_valid = 1'b1; cache_data_in = 64'h1111_2222_3333_4444;
    settle(); chk("a_index", 64'(index_out), 64'd8); chk("a_rd_en", 64'(read_enable), 64'd1); advance();
    clr(); settle();
    chk("a_resp_v", 64'(lsq_resp_valid), 64'd1);
    chk("a_resp_d", lsq_resp_data, 64'h1111_2222_3333_4444);
    chk("a_resp_rob", 64'(lsq_resp_rob_idx), 64'd5);
    advance();
    clr(); settle(); chk("a_resp_once", 64'(lsq_resp_valid), 64'd0); advance();

    // Store hit
    clr(); lsq_req_valid = 1'b1; lsq_req_is_store = 1'b1; lsq_req_addr = 64'h58;
    lsq_req_data = 64'hCAFE; lsq_req_rob_idx = 5'd1; step();
    clr(); data_is_valid = 1'b1; settle();
    chk("s_wr_en", 64'(write_enable), 64'd1); chk("s_wr_data", write_data_out, 64'hCAFE);
    chk("s_rd_en", 64'(read_enable), 64'd0); advance();
    clr(); settle(); chk("s_no_resp", 64'(lsq_resp_valid), 64'd0); chk("s_ready", 64'(lsq_req_ready), 64'd1); advance();

    // Clean load miss: tag 3 returns three cycles after the fill is accepted
    clr(); lsq_req_valid = 1'b1; lsq_req_addr = 64'h80; lsq_req_rob_idx = 5'd7; step();
    clr(); data_is_miss = 1'b1; step();
    clr(); mem_response = 4'd3; settle();
    chk("b_cmd", 64'(mem_command), 64'd1); chk("b_addr", mem_addr, 64'h80); advance();
    clr(); step();
    clr(); step();
    clr(); mem_tag = 4'd3; cache_data_in = 64'hABCD; settle();
    chk("b_not_yet", 64'(lsq_resp_valid), 64'd0); advance();
    clr(); settle();
    chk("b_resp_v", 64'(lsq_resp_valid), 64'd1); chk("b_resp_d", lsq_resp_data, 64'hABCD);
    chk("b_resp_rob", 64'(lsq_resp_rob_idx), 64'd7); advance();

    // Dirty miss: victim 0x12 written back first, each phase stalled twice
    clr(); lsq_req_valid = 1'b1; lsq_req_addr = 64'h2048; lsq_req_rob_idx = 5'd2; step();
    clr(); data_is_miss = 1'b1; data_is_dirty = 1'b1; victim_tag_in = 56'h12; step();
    for (int k = 0; k < 3; k++) begin
      clr(); victim_tag_in = 56'h12; mem_response = (k == 2) ? 4'd5 : 4'd0; settle();
      chk("c_wb_cmd", 64'(mem_command), 64'd2); chk("c_wb_addr", mem_addr, 64'h1248); advance();
    end
    for (int k = 0; k < 3; k++) begin
      clr(); mem_response = (k == 2) ? 4'd6 : 4'd0; settle();
      chk("c_fill_cmd", 64'(mem_command), 64'd1); chk("c_fill_addr", mem_addr, 64'h2048); advance();
    end
    clr(); mem_tag = 4'd6; cache_data_in = 64'h77; step();
    clr(); settle(); chk("c_resp_rob", 64'(lsq_resp_rob_idx), 64'd2); advance();

    // MSHR full
    for (int k = 0; k < 4; k++)
      miss_alloc(64'h1000 + 64'(k) * 64'h100, 5'(k + 10), 4'(k + 8));
    for (int k = 0; k < 2; k++) begin
      clr(); lsq_req_valid = 1'b1; lsq_req_addr = 64'h3000; lsq_req_rob_idx = 5'd20;
      settle(); chk("d_full_ready", 64'(lsq_req_ready), 64'd0); advance();
    end
    clr(); lsq_req_valid = 1'b1; lsq_req_addr = 64'h3000; mem_tag = 4'd9;
    settle(); chk("d_cmpl_ready", 64'(lsq_req_ready), 64'd0); advance();
    clr(); settle(); chk("d_freed_ready", 64'(lsq_req_ready), 64'd1); advance();
    clr(); mem_tag = 4'd8; step();
    clr(); mem_tag = 4'd10; step();
    clr(); mem_tag = 4'd11; step();
    clr(); step();

    // Fill completion collides with a load hit
    miss_alloc(64'h100, 5'd3, 4'd4);
    clr(); lsq_req_valid = 1'b1; lsq_req_addr = 64'h40; lsq_req_rob_idx = 5'd9; step();
    clr(); data_is_valid = 1'b1; cache_data_in = 64'hF111; mem_tag = 4'd4; step();
    clr(); data_is_valid = 1'b1; cache_data_in = 64'hB0B0; settle();
    chk("e_fill_v", 64'(lsq_resp_valid), 64'd1); chk("e_fill_rob", 64'(lsq_resp_rob_idx), 64'd3);
    chk("e_fill_d", lsq_resp_data, 64'hF111); chk("e_replay", 64'(read_enable), 64'd1); advance();
    clr(); settle();
    chk("e_hit_v", 64'(lsq_resp_valid), 64'd1); chk("e_hit_rob", 64'(lsq_resp_rob_idx), 64'd9);
    chk("e_hit_d", lsq_resp_data, 64'hB0B0); advance();

    // Reset with two outstanding fills and one access in flight
    miss_alloc(64'h200, 5'd12, 4'd12);
    miss_alloc(64'h300, 5'd13, 4'd13);
    clr(); lsq_req_valid = 1'b1; lsq_req_addr = 64'h400; lsq_req_rob_idx = 5'd14; step();
    clr(); reset = 1'b1; data_is_miss = 1'b1; settle();
    chk("r_ready", 64'(lsq_req_ready), 64'd0); chk("r_rd_en", 64'(read_enable), 64'd0);
    chk("r_index", 64'(index_out), 64'd0); advance();
    clr(); mem_tag = 4'd12; settle(); chk("r_idle_ready", 64'(lsq_req_ready), 64'd1); advance();
    clr(); mem_tag = 4'd13; settle(); chk("r_drop12", 64'(lsq_resp_valid), 64'd0); advance();
    clr(); settle(); chk("r_drop13", 64'(lsq_resp_valid), 64'd0); advance();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 599) == 0);
      lsq_req_valid = 1'($urandom_range(0, 1));
      lsq_req_is_store = ($urandom_range(0, 2) == 0);
      lsq_req_addr = {$urandom, $urandom};
      lsq_req_data = {$urandom, $urandom};
      lsq_req_rob_idx = 5'($urandom_range(0, 31));
      data_is_valid = ($urandom_range(0, 2) == 0);
      data_is_miss = 1'($urandom_range(0, 1));
      data_is_dirty = ($urandom_range(0, 2) == 0);
      cache_is_full = ($urandom_range(0, 4) == 0);
      cache_data_in = {$urandom, $urandom};
      r64 = {$urandom, $urandom};
      victim_tag_in = r64[55:0];
      r = $urandom_range(0, 1) ? int'($urandom_range(1, 15)) : 0;
      if (r != 0 && tag_busy(r)) r = 0;
      mem_response = 4'(r);
      if ($urandom_range(0, 2) == 0) begin
        j = int'($urandom_range(0, 3));
        mem_tag = fv[j] ? 4'(ft[j]) : 4'($urandom_range(0, 15));
      end else begin
        mem_tag = 4'd0;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
